mips_fetch_unit: RTL
====================

Name: mips_fetch_unit

Overview:
- Instruction fetch front end that produces the opcode stream consumed by the MIPS control decoder. It is the producer end of the Op/Jump/Branch interface.
- Owns the PC. Fetches 32-bit words from instruction memory over a req/ack handshake and holds each instruction in an instruction register (IR). It presents the instruction downstream with valid/ready.
- Computes the next PC from the decoder's Jump/Branch outputs and the ALU zero flag when the held instruction is consumed.
- Keeps a retired-instruction counter.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset. Bits [1:0] must be 0.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock. All state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  word-aligned fetch address (= PC).
- imem_ack  in  1  memory has data valid on imem_rdata this cycle.
- imem_rdata  in  32  fetched instruction word.
- instr_valid  out  1  IR holds an unconsumed instruction.
- instr_ready  in  1  downstream consumes IR this cycle.
- instr  out  32  IR contents.
- op  out  6  instr[31:26], drives the control decoder Op input.
- instr_pc  out  32  PC of the instruction in IR.
- jump  in  1  decoder Jump for the instruction in IR.
- branch  in  1  decoder Branch for the instruction in IR.
- zero  in  1  ALU zero flag for the instruction in IR.
- retired  out  CNT_W  count of consumed instructions.

Behaviour:
- Reset is asynchronous, active-low; reset values take effect immediately.
  - pc = RESET_PC, state = S_BOOT, imem_req = 0, instr_valid = 0, instr = 0, retired = 0.
- All outputs are registered or derived directly from registers. Exception: op is a slice of instr.
- FSM states:
  - S_BOOT: first clock after rst_n deasserts; no request. Next state S_FETCH.
  - S_FETCH: imem_req = 1, imem_addr = pc. Both are held stable until imem_ack.
    - On imem_ack: IR <= imem_rdata, instr_valid <= 1, next state S_HOLD.
    - Ack may arrive in the same cycle req first rises. Minimum latency is req-rise to instr_valid of 1 cycle.
  - S_HOLD: imem_req = 0, instr_valid = 1. IR and instr_pc are stable while instr_ready = 0.
    - On instr_valid && instr_ready (fire): pc <= next_pc, instr_valid <= 0, retired <= retired + 1, next state S_FETCH.
- imem_ack outside S_FETCH is ignored; it must not change IR.
- next_pc arithmetic (32-bit, wraps modulo 2^32):
  - pc4 = pc + 4.
  - jump = 1: next_pc = {pc4[31:28], instr[25:0], 2'b00}. Jump has priority over branch.
  - else branch && zero: next_pc = pc4 + {{14{instr[15]}}, instr[15:0], 2'b00}.
  - else: next_pc = pc4.
- jump, branch and zero are sampled only on the fire cycle. They are don't-care otherwise.
- PC wrap: pc = 32'hFFFF_FFFC, sequential next_pc = 32'h0000_0000.
- retired wraps to 0 at all-ones.
- Throughput: one instruction every 2 cycles at best (zero-wait memory, instr_ready held high).
- rst_n asserted mid-fetch: imem_req drops immediately. A pending or late ack is discarded. Fetch restarts at RESET_PC after S_BOOT.

Decomposition:
- Shared package mips_pkg:
  - Opcode constants OP_RTYPE 6'h00, OP_J 6'h02, OP_BEQ 6'h04, OP_LW 6'h23, OP_SW 6'h2B. Shared with the control decoder and its bench.
  - fetch_state_t enum {S_BOOT, S_FETCH, S_HOLD}.
  - RESET_PC default.
- One combinational sub-module, mips_next_pc: inputs pc, instr, jump, branch, zero; output next_pc. It is verified standalone.

Test Plan:
- Reset release, zero-wait memory with same-cycle ack, instr_ready = 1, jump = branch = 0: imem_addr sequence 0x0, 0x4, 0x8. instr_valid pulses every 2 cycles. retired = 3 after the third fire.
- Memory acks 3 cycles late and instr_ready is held 0 for 4 cycles in S_HOLD: imem_addr is stable throughout the wait, IR is unchanged, no second request, retired is not incremented until fire.
- IR = 32'h1000_FFFF (beq, imm = -1) at pc 0x100:
  - fire with branch = 1, zero = 1: next imem_addr = 0x100.
  - repeat with zero = 0: next imem_addr = 0x104.
- IR = 32'h0800_0040 (j) at pc 0x1000_0000, fire with jump = 1 and branch = 1, zero = 1: next imem_addr = 0x1000_0100 (jump priority).
- rst_n pulsed low while imem_req = 1 at addr 0x8, with ack arriving during reset: imem_req = 0 and instr_valid = 0 immediately. After release, the first request is at RESET_PC. The discarded word never appears on instr.
- RESET_PC = 32'hFFFF_FFFC, sequential fire: next imem_addr = 0x0. retired preset to all-ones wraps to 0 on that fire.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: opcodes, fetch state type and reset PC default shared by the MIPS front end
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J = 6'h02;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2B;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_HOLD} fetch_state_t;
endpackage

// File: rtl/mips_next_pc.sv
// mips_next_pc: sequential / jump / taken-branch next PC selection
module mips_next_pc (
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic        jump,
  input  logic        branch,
  input  logic        zero,
  output logic [31:0] next_pc
);
  logic [31:0] pc4;
  assign pc4 = pc + 32'd4;
  assign next_pc = jump ? {pc4[31:28], instr[25:0], 2'b00} :
                   (branch && zero) ? pc4 + {{14{instr[15]}}, instr[15:0], 2'b00} : pc4;
endmodule

// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit: PC owner fetching words over req/ack and handing them downstream via valid/ready
module mips_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [31:0]      instr,
  output logic [5:0]       op,
  output logic [31:0]      instr_pc,
  input  logic             jump,
  input  logic             branch,
  input  logic             zero,
  output logic [CNT_W-1:0] retired
);
  fetch_state_t state, state_nx;
  logic [31:0] pc, next_pc;
  logic fire;
  assign fire = instr_valid && instr_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_BOOT;
    else state <= state_nx;
  always_comb
    state_nx = (state == S_BOOT) ? S_FETCH :
               (state == S_FETCH) ? (imem_ack ? S_HOLD : S_FETCH) :
               (fire ? S_FETCH : S_HOLD);
  always_comb begin
    imem_req = state == S_FETCH;
    instr_valid = state == S_HOLD;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc <= RESET_PC;
      instr <= '0;
      retired <= '0;
    end else begin
      if (imem_req && imem_ack) instr <= imem_rdata;
      if (fire) begin
        pc <= next_pc;
        retired <= retired + 1'b1;
      end
    end
  mips_next_pc u_next_pc (
    .pc(pc),
    .instr(instr),
    .jump(jump),
    .branch(branch),
    .zero(zero),
    .next_pc(next_pc)
  );
  assign imem_addr = pc;
  assign instr_pc = pc;
  assign op = instr[31:26];
endmodule
